// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: M-mode CSR file, exception/interrupt arbitration, trap entry and mret.
// Optional VECTORED_MODE_EN makes mtvec[1:0] writable and sends interrupts to base+4*code when MODE=01.
module trap_ctrl #(
  parameter int XLEN = 32,
  parameter int NUM_IRQ = 4,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_valid,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               csr_illegal,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               illegal_inst,
  input  logic               ecall_m,
  input  logic               l_access_fault,
  input  logic               s_access_fault,
  input  logic [XLEN-1:0]    tval_in,
  input  logic               mret,
  input  logic [XLEN-1:0]    epc_cur,
  input  logic [XLEN-1:0]    epc_next,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc,
  output logic               flush,
  output logic               regwrite_cancel
);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_REDIRECT = 1'b1;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [XLEN-1:0] LOW2_CLEAR = ~(XLEN'(3));
`ifdef VECTORED_MODE_EN
  localparam logic [XLEN-1:0] MTVEC_MASK = '1;
`else
  localparam logic [XLEN-1:0] MTVEC_MASK = LOW2_CLEAR;
`endif

  logic [0:0]         state_q;
  logic               mstatus_mie_q;
  logic               mstatus_mpie_q;
  logic [NUM_IRQ-1:0] mie_q;
  logic [NUM_IRQ-1:0] mip_q;
  logic [XLEN-1:0]    mtvec_q;
  logic [XLEN-1:0]    mscratch_q;
  logic [XLEN-1:0]    mepc_q;
  logic [XLEN-1:0]    mcause_q;
  logic [XLEN-1:0]    mtval_q;
  logic [XLEN-1:0]    redirect_pc_q;

  logic               addr_ok;
  logic               idle;
  logic               exc;
  logic               intr;
  logic               take_trap;
  logic               take_mret;
  logic               csr_we;
  logic [NUM_IRQ-1:0] pending;
  logic [4:0]         irq_code;
  logic [4:0]         exc_code;
  logic [XLEN-1:0]    trap_cause;
  logic [XLEN-1:0]    trap_epc;
  logic [XLEN-1:0]    trap_tval;
  logic [XLEN-1:0]    trap_target;
  logic [XLEN-1:0]    mtvec_base;
  logic [XLEN-1:0]    csr_new;

  // CSR read mux; unimplemented bits read as zero.
  always_comb begin
    csr_rdata = '0;
    addr_ok   = 1'b1;
    case (csr_addr)
      ADDR_MSTATUS: begin
        csr_rdata[3] = mstatus_mie_q;
        csr_rdata[7] = mstatus_mpie_q;
      end
      ADDR_MIE:      csr_rdata[16 +: NUM_IRQ] = mie_q;
      ADDR_MTVEC:    csr_rdata = mtvec_q;
      ADDR_MSCRATCH: csr_rdata = mscratch_q;
      ADDR_MEPC:     csr_rdata = mepc_q;
      ADDR_MCAUSE:   csr_rdata = mcause_q;
      ADDR_MTVAL:    csr_rdata = mtval_q;
      ADDR_MIP:      csr_rdata[16 +: NUM_IRQ] = mip_q;
      default:       addr_ok = 1'b0;
    endcase
  end

  assign csr_illegal = csr_valid & ~addr_ok;

  always_comb begin
    case (csr_op)
      OP_WRITE: csr_new = csr_wdata;
      OP_SET:   csr_new = csr_rdata | csr_wdata;
      OP_CLEAR: csr_new = csr_rdata & ~csr_wdata;
      default:  csr_new = csr_rdata;
    endcase
  end

  // Lowest-numbered enabled pending line wins.
  always_comb begin
    pending  = mip_q & mie_q;
    irq_code = 5'd16;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) irq_code = 5'(16 + i);
    end
  end

  always_comb begin
    if (illegal_inst)        exc_code = 5'd2;
    else if (ecall_m)        exc_code = 5'd11;
    else if (l_access_fault) exc_code = 5'd5;
    else                     exc_code = 5'd7;
  end

  assign idle      = (state_q == S_IDLE);
  assign exc       = illegal_inst | ecall_m | l_access_fault | s_access_fault;
  assign intr      = mstatus_mie_q & (|pending);
  assign take_trap = idle & (exc | intr);
  assign take_mret = idle & ~(exc | intr) & mret;
  assign csr_we    = idle & ~(exc | intr) & ~mret & csr_valid & (csr_op != 2'b00) & addr_ok;

  assign mtvec_base = {mtvec_q[XLEN-1:2], 2'b00};

  // Exceptions always take precedence over a simultaneous interrupt.
  always_comb begin
    if (exc) begin
      trap_cause = XLEN'(exc_code);
      trap_epc   = epc_cur;
      trap_tval  = (~illegal_inst & ecall_m) ? '0 : tval_in;
    end else begin
      trap_cause = {1'b1, (XLEN-1)'(irq_code)};
      trap_epc   = epc_next;
      trap_tval  = '0;
    end
  end

`ifdef VECTORED_MODE_EN
  assign trap_target = (!exc && mtvec_q[1:0] == 2'b01)
                       ? mtvec_base + (XLEN'(irq_code) << 2)
                       : mtvec_base;
`else
  assign trap_target = mtvec_base;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mip_q          <= '0;
      mtvec_q        <= MTVEC_RESET & MTVEC_MASK;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      redirect_pc_q  <= '0;
    end else begin
      mip_q <= irq;
      case (state_q)
        S_IDLE: begin
          if (take_trap) begin
            mepc_q         <= trap_epc & LOW2_CLEAR;
            mcause_q       <= trap_cause;
            mtval_q        <= trap_tval;
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
            redirect_pc_q  <= trap_target;
            state_q        <= S_REDIRECT;
          end else if (take_mret) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
            redirect_pc_q  <= mepc_q;
            state_q        <= S_REDIRECT;
          end else if (csr_we) begin
            case (csr_addr)
              ADDR_MSTATUS: begin
                mstatus_mie_q  <= csr_new[3];
                mstatus_mpie_q <= csr_new[7];
              end
              ADDR_MIE:      mie_q      <= csr_new[16 +: NUM_IRQ];
              ADDR_MTVEC:    mtvec_q    <= csr_new & MTVEC_MASK;
              ADDR_MSCRATCH: mscratch_q <= csr_new;
              ADDR_MEPC:     mepc_q     <= csr_new & LOW2_CLEAR;
              ADDR_MCAUSE:   mcause_q   <= csr_new;
              ADDR_MTVAL:    mtval_q    <= csr_new;
              default: ;
            endcase
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign redirect_valid  = (state_q == S_REDIRECT);
  assign redirect_pc     = redirect_pc_q;
  assign flush           = ~rst & (~idle | take_trap | take_mret);
  assign regwrite_cancel = ~rst & take_trap;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: expectations are queued by the stimulus, popped by a negedge monitor.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_valid;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [3:0]  irq;
  logic        illegal_inst, ecall_m, l_access_fault, s_access_fault, mret;
  logic [31:0] tval_in, epc_cur, epc_next;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush, regwrite_cancel;

  typedef struct {
    bit          is_redir;
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

`ifdef VECTORED_MODE_EN
  localparam logic [31:0] MTVEC_101_RD = 32'h101;
  localparam logic [31:0] MTVEC_103_RD = 32'h103;
  localparam logic [31:0] IRQ0_TARGET  = 32'h140;
`else
  localparam logic [31:0] MTVEC_101_RD = 32'h100;
  localparam logic [31:0] MTVEC_103_RD = 32'h100;
  localparam logic [31:0] IRQ0_TARGET  = 32'h100;
`endif

  trap_ctrl dut (
    .clk(clk), .rst(rst),
    .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .irq(irq),
    .illegal_inst(illegal_inst), .ecall_m(ecall_m),
    .l_access_fault(l_access_fault), .s_access_fault(s_access_fault),
    .tval_in(tval_in), .mret(mret), .epc_cur(epc_cur), .epc_next(epc_next),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .regwrite_cancel(regwrite_cancel)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pop_check(input bit is_redir, input logic [31:0] act);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL unexpected_%s: got 0x%08h, expected no event", is_redir ? "redirect" : "read", act);
    end else begin
      e = sb.pop_front();
      if (e.is_redir != is_redir) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s: got wrong event kind, value 0x%08h, expected 0x%08h", e.name, act, e.val);
      end else begin
        checkOutput(e.name, act, e.val);
      end
    end
  endtask

  // Monitor: redirects and CSR reads (csr_op=00) both consume the next queued expectation.
  always @(negedge clk) begin
    if (redirect_valid === 1'b1) pop_check(1'b1, redirect_pc);
    if (csr_valid === 1'b1 && csr_op === 2'b00) pop_check(1'b0, csr_rdata);
  end

  task automatic push_exp(input bit is_redir, input string name, input logic [31:0] val);
    exp_t e;
    e.is_redir = is_redir;
    e.name     = name;
    e.val      = val;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    illegal_inst   = 1'b0;
    ecall_m        = 1'b0;
    l_access_fault = 1'b0;
    s_access_fault = 1'b0;
    mret           = 1'b0;
  endtask

  task automatic clear_csr();
    csr_valid = 1'b0;
    csr_op    = 2'b00;
    csr_addr  = 12'h000;
    csr_wdata = 32'h0;
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data);
    csr_valid = 1'b1;
    csr_op    = op;
    csr_addr  = addr;
    csr_wdata = data;
    tick();
    clear_csr();
  endtask

  task automatic csr_read(input logic [11:0] addr, input logic [31:0] exp, input string name);
    push_exp(1'b0, name, exp);
    applyStimulus(2'b00, addr, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clear_csr();
    clear_events();
    irq = '0; tval_in = '0; epc_cur = '0; epc_next = '0;
    rst = 1'b1;
    illegal_inst = 1'b1;
    tick();
    checkOutput("flush_in_reset", 32'(flush), 32'h0);
    checkOutput("cancel_in_reset", 32'(regwrite_cancel), 32'h0);
    checkOutput("redirect_valid_reset", 32'(redirect_valid), 32'h0);
    illegal_inst = 1'b0;
    tick();
    rst = 1'b0;
    csr_read(12'h305, 32'h0, "mtvec_reset");
    csr_read(12'h300, 32'h0, "mstatus_reset");
    csr_read(12'h342, 32'h0, "mcause_reset");

    $display("[TB] illegal instruction trap");
    applyStimulus(2'b01, 12'h305, 32'h100);
    csr_read(12'h305, 32'h100, "mtvec_write");
    push_exp(1'b1, "illegal_redirect", 32'h100);
    illegal_inst = 1'b1; epc_cur = 32'h40; tval_in = 32'h0000FFFF;
    #1;
    checkOutput("illegal_flush", 32'(flush), 32'h1);
    checkOutput("illegal_cancel", 32'(regwrite_cancel), 32'h1);
    tick();
    clear_events();
    checkOutput("redirect_cycle_flush", 32'(flush), 32'h1);
    tick();
    csr_read(12'h341, 32'h40, "illegal_mepc");
    csr_read(12'h342, 32'h2, "illegal_mcause");
    csr_read(12'h343, 32'hFFFF, "illegal_mtval");
    csr_read(12'h300, 32'h0, "illegal_mstatus");

    $display("[TB] interrupt trap");
    applyStimulus(2'b01, 12'h305, 32'h101);
    csr_read(12'h305, MTVEC_101_RD, "mtvec_mode_bits");
    applyStimulus(2'b01, 12'h304, 32'h10000);
    applyStimulus(2'b01, 12'h300, 32'h8);
    push_exp(1'b1, "irq_redirect", IRQ0_TARGET);
    irq = 4'b0001; epc_next = 32'h80;
    tick();
    checkOutput("irq_flush", 32'(flush), 32'h1);
    tick();
    tick();
    csr_read(12'h342, 32'h80000010, "irq_mcause");
    csr_read(12'h341, 32'h80, "irq_mepc");
    csr_read(12'h300, 32'h80, "irq_mstatus");
    csr_read(12'h344, 32'h10000, "irq_mip");

    $display("[TB] ecall beats pending interrupt");
    applyStimulus(2'b01, 12'h300, 32'h8);
    push_exp(1'b1, "ecall_redirect", 32'h100);
    ecall_m = 1'b1; epc_cur = 32'h300; tval_in = 32'hDEAD;
    tick();
    clear_events();
    tick();
    csr_read(12'h342, 32'd11, "ecall_mcause");
    csr_read(12'h343, 32'h0, "ecall_mtval");
    csr_read(12'h341, 32'h300, "ecall_mepc");
    csr_read(12'h344, 32'h10000, "ecall_mip_pending");
    csr_read(12'h300, 32'h80, "ecall_mstatus");
    irq = '0;
    tick();
    tick();
    csr_read(12'h344, 32'h0, "mip_cleared");

    $display("[TB] mret");
    applyStimulus(2'b01, 12'h341, 32'h200);
    push_exp(1'b1, "mret_redirect", 32'h200);
    mret = 1'b1;
    #1;
    checkOutput("mret_flush", 32'(flush), 32'h1);
    checkOutput("mret_no_cancel", 32'(regwrite_cancel), 32'h0);
    tick();
    mret = 1'b0;
    tick();
    csr_read(12'h300, 32'h88, "mret_mstatus");
    applyStimulus(2'b01, 12'h300, 32'h0);

    $display("[TB] CSR set/clear and masking");
    applyStimulus(2'b01, 12'h304, 32'h0);
    applyStimulus(2'b10, 12'h304, 32'h30000);
    csr_read(12'h304, 32'h30000, "mie_set");
    applyStimulus(2'b11, 12'h304, 32'h10000);
    csr_read(12'h304, 32'h20000, "mie_clear");
    applyStimulus(2'b10, 12'h304, 32'hFFFF_FFFF);
    csr_read(12'h304, 32'h000F0000, "mie_mask");
    applyStimulus(2'b01, 12'h304, 32'h20000);
    csr_valid = 1'b1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'hA5A5A5A5;
    #1;
    checkOutput("legal_addr", 32'(csr_illegal), 32'h0);
    tick();
    clear_csr();
    applyStimulus(2'b10, 12'h340, 32'h0);
    applyStimulus(2'b11, 12'h340, 32'h0);
    csr_read(12'h340, 32'hA5A5A5A5, "mscratch_zero_setclr");
    csr_valid = 1'b1; csr_op = 2'b01; csr_addr = 12'h7C0; csr_wdata = 32'hFFFFFFFF;
    #1;
    checkOutput("illegal_addr", 32'(csr_illegal), 32'h1);
    tick();
    clear_csr();
    csr_read(12'h340, 32'hA5A5A5A5, "illegal_no_write_mscratch");
    csr_read(12'h304, 32'h20000, "illegal_no_write_mie");
    applyStimulus(2'b01, 12'h341, 32'h203);
    csr_read(12'h341, 32'h200, "mepc_low_bits");
    applyStimulus(2'b01, 12'h305, 32'h103);
    csr_read(12'h305, MTVEC_103_RD, "mtvec_low_bits");
    applyStimulus(2'b01, 12'h305, 32'h100);

    $display("[TB] double exception, CSR writes dropped");
    push_exp(1'b1, "dual_redirect", 32'h100);
    illegal_inst = 1'b1; l_access_fault = 1'b1; epc_cur = 32'h44; tval_in = 32'h1234;
    csr_valid = 1'b1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h22222222;
    tick();
    clear_events();
    csr_wdata = 32'h11111111; mret = 1'b1; ecall_m = 1'b1;
    tick();
    clear_events();
    clear_csr();
    csr_read(12'h342, 32'h2, "dual_mcause");
    csr_read(12'h343, 32'h1234, "dual_mtval");
    csr_read(12'h341, 32'h44, "dual_mepc");
    csr_read(12'h340, 32'hA5A5A5A5, "dual_mscratch_kept");

    $display("[TB] load fault beats store fault");
    push_exp(1'b1, "fault_redirect", 32'h100);
    l_access_fault = 1'b1; s_access_fault = 1'b1; epc_cur = 32'h48; tval_in = 32'h500;
    tick();
    clear_events();
    tick();
    csr_read(12'h342, 32'h5, "load_fault_mcause");
    csr_read(12'h343, 32'h500, "load_fault_mtval");

    $display("[TB] reset during redirect");
    push_exp(1'b1, "store_redirect", 32'h100);
    s_access_fault = 1'b1; tval_in = 32'h600;
    tick();
    clear_events();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("redirect_after_reset", 32'(redirect_valid), 32'h0);
    csr_read(12'h305, 32'h0, "mtvec_after_reset");
    csr_read(12'h342, 32'h0, "mcause_after_reset");
    csr_read(12'h340, 32'h0, "mscratch_after_reset");

    repeat (3) tick();
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
